// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: decodes B322 CPU word requests onto SDRAM, ROM and VRAM ports.
// Latency: ROM/VRAM read 2 busy cycles, VRAM write and error 1 cycle, SDRAM ack-driven with timeout.
// Backpressure: busy is high while an access is in flight; start is ignored until it drops.
module mem_bus_ctrl #(
    parameter logic [26:0] ROM_BASE      = 27'h4000000,
    parameter logic [26:0] VRAM_BASE     = 27'h4000400,
    parameter int          WIN_AW        = 10,
    parameter int          SDRAM_TIMEOUT = 1023,
    parameter logic [31:0] UNMAPPED_Q    = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              we,
    input  logic [26:0]       address,
    input  logic [31:0]       data,
    output logic [31:0]       q,
    output logic              busy,
    output logic [WIN_AW-1:0] rom_addr,
    input  logic [31:0]       rom_q,
    output logic [WIN_AW-1:0] vram_addr,
    output logic [31:0]       vram_d,
    output logic              vram_we,
    input  logic [31:0]       vram_q,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [25:0]       sdram_addr,
    output logic [31:0]       sdram_d,
    input  logic [31:0]       sdram_q,
    input  logic              sdram_ack,
    output logic              bus_err
);

    localparam int          CW       = (SDRAM_TIMEOUT > 1) ? $clog2(SDRAM_TIMEOUT + 1) : 1;
    localparam logic [27:0] ROM_END  = {1'b0, ROM_BASE} + (28'd1 << WIN_AW);
    localparam logic [27:0] VRAM_END = {1'b0, VRAM_BASE} + (28'd1 << WIN_AW);

    typedef enum logic [2:0] {
        S_IDLE, S_ROM_RD, S_VRAM_RD, S_CAPTURE, S_SDRAM_WAIT, S_ERR
    } state_t;

    state_t            state_q;
    logic [31:0]       q_q;
    logic              busy_q, bus_err_q, we_q, src_rom_q;
    logic [WIN_AW-1:0] rom_addr_q, vram_addr_q;
    logic [31:0]       vram_d_q, sdram_d_q;
    logic              vram_we_q, sdram_req_q, sdram_we_q;
    logic [25:0]       sdram_addr_q;
    logic [CW-1:0]     cnt_q;

    logic              is_sdram, is_rom, is_vram;
    logic [WIN_AW-1:0] rom_off, vram_off;

    // Address decode: SDRAM owns the lower half, ROM/VRAM are small windows in the upper half
    assign is_sdram = ~address[26];
    assign is_rom   = ({1'b0, address} >= {1'b0, ROM_BASE})  && ({1'b0, address} < ROM_END);
    assign is_vram  = ({1'b0, address} >= {1'b0, VRAM_BASE}) && ({1'b0, address} < VRAM_END);
    assign rom_off  = address[WIN_AW-1:0] - ROM_BASE[WIN_AW-1:0];
    assign vram_off = address[WIN_AW-1:0] - VRAM_BASE[WIN_AW-1:0];

    // Request FSM; every output is a register so strobes are glitch-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            q_q          <= '0;
            busy_q       <= 1'b0;
            bus_err_q    <= 1'b0;
            we_q         <= 1'b0;
            src_rom_q    <= 1'b0;
            rom_addr_q   <= '0;
            vram_addr_q  <= '0;
            vram_d_q     <= '0;
            vram_we_q    <= 1'b0;
            sdram_req_q  <= 1'b0;
            sdram_we_q   <= 1'b0;
            sdram_addr_q <= '0;
            sdram_d_q    <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        bus_err_q <= 1'b0;
                        we_q      <= we;
                        if (is_sdram) begin
                            sdram_req_q  <= 1'b1;
                            sdram_we_q   <= we;
                            sdram_addr_q <= address[25:0];
                            sdram_d_q    <= data;
                            cnt_q        <= '0;
                            state_q      <= S_SDRAM_WAIT;
                        end else if (is_rom && !we) begin
                            rom_addr_q <= rom_off;
                            src_rom_q  <= 1'b1;
                            state_q    <= S_ROM_RD;
                        end else if (is_vram) begin
                            vram_addr_q <= vram_off;
                            src_rom_q   <= 1'b0;
                            if (we) begin
                                // Write strobe lives for the single CAPTURE cycle
                                vram_we_q <= 1'b1;
                                vram_d_q  <= data;
                                state_q   <= S_CAPTURE;
                            end else begin
                                state_q <= S_VRAM_RD;
                            end
                        end else begin
                            // ROM write or hole in the map
                            state_q <= S_ERR;
                        end
                    end
                end
                S_ROM_RD, S_VRAM_RD: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // Retires both synchronous reads and the one-cycle VRAM write
                    vram_we_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (!we_q) begin
                        q_q <= src_rom_q ? rom_q : vram_q;
                    end
                    state_q <= S_IDLE;
                end
                S_SDRAM_WAIT: begin
                    if (sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        busy_q      <= 1'b0;
                        if (!we_q) begin
                            q_q <= sdram_q;
                        end
                        state_q <= S_IDLE;
                    end else if (cnt_q == CW'(SDRAM_TIMEOUT - 1)) begin
                        sdram_req_q <= 1'b0;
                        busy_q      <= 1'b0;
                        bus_err_q   <= 1'b1;
                        if (!we_q) begin
                            q_q <= UNMAPPED_Q;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_ERR: begin
                    busy_q    <= 1'b0;
                    bus_err_q <= 1'b1;
                    if (!we_q) begin
                        q_q <= UNMAPPED_Q;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign q          = q_q;
    assign busy       = busy_q;
    assign bus_err    = bus_err_q;
    assign rom_addr   = rom_addr_q;
    assign vram_addr  = vram_addr_q;
    assign vram_d     = vram_d_q;
    assign vram_we    = vram_we_q;
    assign sdram_req  = sdram_req_q;
    assign sdram_we   = sdram_we_q;
    assign sdram_addr = sdram_addr_q;
    assign sdram_d    = sdram_d_q;

endmodule
